cnn_ofmap_writer: RTL and testbench

//  Write-side sequencer for one output feature map (ofmap). Accepts result pixels from the

---
 rtl/cnn_pkg.sv | 16 +
 rtl/cnn_fifo.sv | 53 +++++
 rtl/cnn_ofmap_writer.sv | 159 +++++++++++++++
 tb/tb_cnn_ofmap_writer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared types and sizing helpers for the CNN ofmap write path.
package cnn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } ofmap_wr_state_e;

    // Bits needed to count 0..w*h inclusive.
    function automatic int pix_cnt_width(input int w, input int h);
        return $clog2(w * h + 1);
    endfunction

endpackage

// File: rtl/cnn_fifo.sv
// Synchronous FIFO with registered storage; full/empty derived from wrap-bit pointers.
module cnn_fifo #(
    parameter int data_width_p = 16,
    parameter int fifo_depth_p = 4
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    push_i,
    input  logic [data_width_p-1:0] data_i,
    input  logic                    pop_i,
    output logic [data_width_p-1:0] data_o,
    output logic                    full_o,
    output logic                    empty_o
);

    localparam int PtrW = $clog2(fifo_depth_p);

    logic [data_width_p-1:0] mem_q [fifo_depth_p];
    logic [PtrW:0]           wr_ptr_q;
    logic [PtrW:0]           rd_ptr_q;
    logic                    push_en_s;
    logic                    pop_en_s;

    assign full_o    = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                       (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign push_en_s = push_i && !full_o;
    assign pop_en_s  = pop_i && !empty_o;
    assign data_o    = mem_q[rd_ptr_q[PtrW-1:0]];

    // Pointer update; reset empties the FIFO.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_en_s) begin
                wr_ptr_q <= wr_ptr_q + (PtrW+1)'(1);
            end
            if (pop_en_s) begin
                rd_ptr_q <= rd_ptr_q + (PtrW+1)'(1);
            end
        end
    end

    // Storage write; contents are don't-care until pushed.
    always_ff @(posedge clk_i) begin
        if (push_en_s) begin
            mem_q[wr_ptr_q[PtrW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/cnn_ofmap_writer.sv
// Ofmap write sequencer: buffers result pixels and writes them in raster order,
// then pulses done_o for one cycle.
module cnn_ofmap_writer
    import cnn_pkg::*;
#(
    parameter int width_p      = 8,
    parameter int height_p     = 8,
    parameter int data_width_p = 16,
    parameter int addr_width_p = 16,
    parameter int fifo_depth_p = 4
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic                            start_i,
    input  logic [addr_width_p-1:0]         base_addr_i,
    input  logic                            valid_i,
    input  logic [data_width_p-1:0]         data_i,
    output logic                            ready_o,
    output logic                            we_o,
    output logic [addr_width_p-1:0]         addr_o,
    output logic [data_width_p-1:0]         wdata_o,
    input  logic                            mem_ready_i,
    output logic [$clog2(height_p):0]       row_o,
    output logic [$clog2(width_p):0]        col_o,
    output logic                            busy_o,
    output logic                            done_o
);

    localparam int CntW = pix_cnt_width(width_p, height_p);
    localparam int RowW = $clog2(height_p) + 1;
    localparam int ColW = $clog2(width_p) + 1;
    localparam int Last = width_p * height_p - 1;

    ofmap_wr_state_e         state_q, state_d;
    logic [addr_width_p-1:0] base_q, base_d;
    logic [CntW-1:0]         in_cnt_q, in_cnt_d;
    logic [CntW-1:0]         out_cnt_q, out_cnt_d;
    logic [RowW-1:0]         row_q, row_d;
    logic [ColW-1:0]         col_q, col_d;

    logic                    fifo_full_s;
    logic                    fifo_empty_s;
    logic [data_width_p-1:0] fifo_head_s;
    logic                    ready_s;
    logic                    we_s;
    logic                    accept_s;
    logic                    fire_s;

    assign busy_o   = (state_q == RUN) || (state_q == DRAIN);
    assign ready_s  = (state_q == RUN) && !fifo_full_s;
    assign we_s     = busy_o && !fifo_empty_s;
    assign accept_s = valid_i && ready_s;
    assign fire_s   = we_s && mem_ready_i;

    assign ready_o  = ready_s;
    assign we_o     = we_s;
    assign wdata_o  = we_s ? fifo_head_s : '0;
    assign addr_o   = base_q + addr_width_p'(out_cnt_q);
    assign row_o    = row_q;
    assign col_o    = col_q;
    assign done_o   = (state_q == DONE);

    cnn_fifo #(
        .data_width_p (data_width_p),
        .fifo_depth_p (fifo_depth_p)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (accept_s),
        .data_i  (data_i),
        .pop_i   (fire_s),
        .data_o  (fifo_head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    // Next-state: FSM transitions plus pixel/position counters.
    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        row_d     = row_q;
        col_d     = col_q;

        if (accept_s) begin
            in_cnt_d = in_cnt_q + CntW'(1);
        end else begin
            in_cnt_d = in_cnt_q;
        end

        if (fire_s) begin
            out_cnt_d = out_cnt_q + CntW'(1);
            if (col_q == ColW'(width_p - 1)) begin
                col_d = '0;
                row_d = row_q + RowW'(1);
            end else begin
                col_d = col_q + ColW'(1);
            end
        end else begin
            out_cnt_d = out_cnt_q;
        end

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d   = RUN;
                    base_d    = base_addr_i;
                    in_cnt_d  = '0;
                    out_cnt_d = '0;
                    row_d     = '0;
                    col_d     = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (accept_s && (in_cnt_q == CntW'(Last))) begin
                    state_d = DRAIN;
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if (fire_s && (out_cnt_q == CntW'(Last))) begin
                    state_d = DONE;
                end else begin
                    state_d = DRAIN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            base_q    <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            row_q     <= '0;
            col_q     <= '0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            row_q     <= row_d;
            col_q     <= col_d;
        end
    end

endmodule

// File: tb/tb_cnn_ofmap_writer.sv
// Scoreboard bench for cnn_ofmap_writer (3x2 frame, 4-entry FIFO).
module tb_cnn_ofmap_writer;

    localparam int W    = 3;
    localparam int H    = 2;
    localparam int DW   = 16;
    localparam int AW   = 16;
    localparam int FD   = 4;
    localparam int RW   = $clog2(H) + 1;
    localparam int CW   = $clog2(W) + 1;
    localparam int NPIX = W * H;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          start_i;
    logic [AW-1:0] base_addr_i;
    logic          valid_i;
    logic [DW-1:0] data_i;
    logic          ready_o;
    logic          we_o;
    logic [AW-1:0] addr_o;
    logic [DW-1:0] wdata_o;
    logic          mem_ready_i;
    logic [RW-1:0] row_o;
    logic [CW-1:0] col_o;
    logic          busy_o;
    logic          done_o;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [RW-1:0] row;
        logic [CW-1:0] col;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  wr_frame = 0;
    int  done_cnt = 0;

    always #5 clk_i = ~clk_i;

    cnn_ofmap_writer #(
        .width_p      (W),
        .height_p     (H),
        .data_width_p (DW),
        .addr_width_p (AW),
        .fifo_depth_p (FD)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .valid_i     (valid_i),
        .data_i      (data_i),
        .ready_o     (ready_o),
        .we_o        (we_o),
        .addr_o      (addr_o),
        .wdata_o     (wdata_o),
        .mem_ready_i (mem_ready_i),
        .row_o       (row_o),
        .col_o       (col_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: every presented write must match the scoreboard head; fired writes pop it.
    always @(negedge clk_i) begin
        if (!reset_i && we_o) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0h data %0h, expected no write", addr_o, wdata_o);
            end else begin
                check("write", {27'd0, addr_o, wdata_o, row_o, col_o}, {27'd0, exp_q[0]});
                if (mem_ready_i) begin
                    void'(exp_q.pop_front());
                    wr_frame++;
                end
            end
        end
    end

    // vmode: 0 valid always, 1 valid 0110...; mmode: 0 ready always, 1 stalled 10 cycles, 2 toggling 1010...
    task automatic run_frame(input logic [AW-1:0] base, input logic [DW-1:0] d0,
                             input int vmode, input int mmode, input bit mid_start,
                             input int abort_after);
        int k   = 0;
        int c   = 0;
        bit fin = 1'b0;
        wr_frame = 0;
        done_cnt = 0;
        @(posedge clk_i); #1;
        start_i     = 1'b1;
        base_addr_i = base;
        valid_i     = 1'b0;
        mem_ready_i = 1'b0;
        @(negedge clk_i);
        check("done_low_before_start", {63'd0, done_o}, 64'd0);
        check("ready_low_in_idle", {63'd0, ready_o}, 64'd0);
        while (!fin && c < 200) begin
            @(posedge clk_i); #1;
            start_i     = mid_start && (c == 2);
            base_addr_i = (mid_start && c == 2) ? 16'h0200 : base;
            if (abort_after > 0 && wr_frame >= abort_after) begin
                reset_i     = 1'b1;
                valid_i     = 1'b0;
                mem_ready_i = 1'b0;
                start_i     = 1'b0;
                @(posedge clk_i);
                @(negedge clk_i);
                check("outputs_after_reset",
                      {23'd0, we_o, ready_o, busy_o, done_o, addr_o, wdata_o, row_o, col_o}, 64'd0);
                @(posedge clk_i); #1;
                reset_i = 1'b0;
                exp_q.delete();
                return;
            end
            valid_i     = (k < NPIX) && (vmode == 0 || (c % 4 == 1) || (c % 4 == 2));
            data_i      = d0 + DW'(k);
            mem_ready_i = (mmode == 0) || (mmode == 1 && c >= 10) || (mmode == 2 && c % 2 == 0);
            @(negedge clk_i);
            if (mmode == 1 && c == 9) begin
                check("accepted_while_stalled", 64'(k), 64'd4);
                check("ready_low_when_full", {63'd0, ready_o}, 64'd0);
            end
            if (valid_i && ready_o) begin
                exp_q.push_back(wr_t'{AW'(base + AW'(k)), DW'(d0 + DW'(k)), RW'(k / W), CW'(k % W)});
                k++;
            end
            if (done_o) begin
                done_cnt++;
                fin = 1'b1;
            end
            c++;
        end
        if (!fin) begin
            n_checks++;
            n_fail++;
            $display("FAIL frame_timeout: got no done_o after %0d cycles, expected done_o", c);
        end
        check("pixels_accepted", 64'(k), 64'(NPIX));
        check("writes_fired", 64'(wr_frame), 64'(NPIX));
        check("done_pulses", 64'(done_cnt), 64'd1);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        reset_i     = 1'b1;
        start_i     = 1'b0;
        base_addr_i = '0;
        valid_i     = 1'b0;
        data_i      = '0;
        mem_ready_i = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("reset_outputs",
              {23'd0, we_o, ready_o, busy_o, done_o, addr_o, wdata_o, row_o, col_o}, 64'd0);
        @(posedge clk_i); #1;
        reset_i = 1'b0;

        run_frame(16'h0100, 16'd1,  0, 0, 1'b0, 0);   // streaming
        run_frame(16'h0100, 16'd11, 0, 1, 1'b0, 0);   // memory stalled until FIFO fills
        run_frame(16'h0100, 16'd21, 1, 2, 1'b0, 0);   // gapped input, toggling memory
        run_frame(16'h0100, 16'd31, 0, 2, 1'b1, 0);   // start ignored mid-frame
        run_frame(16'h0100, 16'd41, 0, 0, 1'b0, 3);   // reset after 3 writes
        run_frame(16'h0000, 16'd51, 0, 0, 1'b0, 0);   // clean frame after abort
        run_frame(16'hFFFE, 16'd61, 0, 0, 1'b0, 0);   // address wrap
        run_frame(16'h0040, 16'd71, 1, 0, 1'b0, 0);   // back-to-back frame

        @(posedge clk_i); #1;
        @(negedge clk_i);
        check("done_single_cycle", {63'd0, done_o}, 64'd0);
        check("idle_after_frame", {63'd0, busy_o}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
